// File: rtl/mips_fetch_unit_if.sv
// +----------------------------------------------------------------------------+
// | Module  : mips_fetch_unit_if                                               |
// | Desc    : Instruction-memory request/ready bus of the MIPS fetch stage.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mips_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mips_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | Module  : mips_fetch_unit                                                  |
// | Desc    : PC holder and 2-state fetch/exec sequencer feeding decode.       |
// |           Optional macro FETCH_JR_EN adds a register-indirect jump (jr).   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic               clk,
  input  wire logic               reset,
  mips_fetch_unit_if.master       imem,
  output logic [31:0]             instr,
  output logic                    instr_valid,
  output logic [31:0]             pc,
  output logic [31:0]             pcplus4,
  input  wire logic               retire,
  input  wire logic               branch,
  input  wire logic               branchne,
  input  wire logic               zero,
  input  wire logic               jump,
  input  wire logic [31:0]        signimm,
`ifdef FETCH_JR_EN
  input  wire logic               jr,
  input  wire logic [31:0]        jr_target,
`endif
  output logic [31:0]             icount
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] icount_q;
  logic        valid_q;
  logic        req_q;

  logic        taken;
  logic [31:0] pcplus4_w;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] pc_d;

  assign pcplus4_w  = pc_q + 32'd4;
  assign taken      = (branch & zero) | (branchne & ~zero);
  assign branch_tgt = pcplus4_w + {signimm[29:0], 2'b00};
  assign jump_tgt   = {pcplus4_w[31:28], instr_q[25:0], 2'b00};

  // Priority: jr (optional) > jump > taken branch > sequential.
  always_comb begin
    pc_d = pcplus4_w;
    if (jump) begin
      pc_d = jump_tgt;
    end else if (taken) begin
      pc_d = branch_tgt;
    end
`ifdef FETCH_JR_EN
    if (jr) begin
      pc_d = {jr_target[31:2], 2'b00};
    end
`endif
  end

`ifdef FETCH_JR_EN
  logic unused_bits;
  assign unused_bits = ^{signimm[31:30], jr_target[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^signimm[31:30];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      icount_q <= 32'd0;
      valid_q  <= 1'b0;
      req_q    <= 1'b1;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem.imem_ready) begin
            instr_q <= imem.imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (retire) begin
            pc_q     <= pc_d;
            icount_q <= icount_q + 32'd1;
            valid_q  <= 1'b0;
            req_q    <= 1'b1;
            state_q  <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_FETCH;
          valid_q <= 1'b0;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

  // Request is forced low combinationally so it never escapes during reset.
  assign imem.imem_req  = req_q & ~reset;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign pcplus4        = pcplus4_w;
  assign icount         = icount_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_mips_fetch_unit                                               |
// | Desc    : Directed + randomized bench with a per-instruction PC model.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mips_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_JR_EN
  localparam bit JR_EN = 1'b1;
`else
  localparam bit JR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, pc, pcplus4, icount, signimm, jr_target;
  logic        instr_valid, retire, branch, branchne, zero, jump, jr;

  mips_fetch_unit_if bus ();

  mips_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (bus.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .retire      (retire),
    .branch      (branch),
    .branchne    (branchne),
    .zero        (zero),
    .jump        (jump),
    .signimm     (signimm),
`ifdef FETCH_JR_EN
    .jr          (jr),
    .jr_target   (jr_target),
`endif
    .icount      (icount)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_icount;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next PC straight from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                           input logic br, input logic bne, input logic z,
                                           input logic j, input logic [31:0] simm,
                                           input logic jr_v, input logic [31:0] jrt);
    logic [31:0] p4;
    logic [31:0] idx;
    p4  = cur + 32'd4;
    idx = word & 32'h03FF_FFFF;
    if (JR_EN && jr_v)                 return jrt & 32'hFFFF_FFFC;
    if (j)                             return (p4 & 32'hF000_0000) | (idx * 4);
    if ((br && z) || (bne && !z))      return p4 + simm * 4;
    return p4;
  endfunction

  task automatic scramble_ctrl();
    branch    = 1'($urandom_range(0, 1));
    branchne  = 1'($urandom_range(0, 1));
    zero      = 1'($urandom_range(0, 1));
    jump      = 1'($urandom_range(0, 1));
    jr        = 1'($urandom_range(0, 1));
    signimm   = $urandom;
    jr_target = $urandom;
  endtask

  task automatic run_instr(input logic [31:0] word, input int w, input int h,
                           input logic br, input logic bne, input logic z, input logic j,
                           input logic [31:0] simm, input logic jr_v, input logic [31:0] jrt);
    check_eq("fetch_req",   {31'b0, bus.imem_req}, 32'd1);
    check_eq("fetch_addr",  bus.imem_addr, m_pc);
    check_eq("fetch_valid", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < w; i++) begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
      retire         = 1'($urandom_range(0, 1));
      scramble_ctrl();
      tick();
      check_eq("wait_req",   {31'b0, bus.imem_req}, 32'd1);
      check_eq("wait_addr",  bus.imem_addr, m_pc);
      check_eq("wait_valid", {31'b0, instr_valid}, 32'd0);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    retire         = 1'($urandom_range(0, 1));
    tick();
    check_eq("exec_valid",  {31'b0, instr_valid}, 32'd1);
    check_eq("exec_instr",  instr, word);
    check_eq("exec_pc",     pc, m_pc);
    check_eq("exec_pc4",    pcplus4, m_pc + 32'd4);
    check_eq("exec_req",    {31'b0, bus.imem_req}, 32'd0);
    check_eq("exec_icount", icount, m_icount);
    for (int i = 0; i < h; i++) begin
      retire         = 1'b0;
      bus.imem_ready = 1'($urandom_range(0, 1));
      bus.imem_rdata = $urandom;
      scramble_ctrl();
      tick();
      check_eq("hold_valid", {31'b0, instr_valid}, 32'd1);
      check_eq("hold_instr", instr, word);
      check_eq("hold_pc",    pc, m_pc);
    end
    bus.imem_ready = 1'($urandom_range(0, 1));
    bus.imem_rdata = $urandom;
    branch = br; branchne = bne; zero = z; jump = j; signimm = simm;
    jr = jr_v; jr_target = jrt;
    retire = 1'b1;
    tick();
    retire         = 1'b0;
    bus.imem_ready = 1'b0;
    m_pc     = ref_next(m_pc, word, br, bne, z, j, simm, jr_v, jrt);
    m_icount = m_icount + 32'd1;
    check_eq("ret_icount", icount, m_icount);
  endtask

  task automatic plain(input int w);
    run_instr($urandom, w, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] off;
    reset = 1'b1; retire = 1'b0; branch = 1'b0; branchne = 1'b0; zero = 1'b0;
    jump = 1'b0; jr = 1'b0; signimm = 32'd0; jr_target = 32'd0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'd0;
    tick();
    tick();
    check_eq("rst_req",    {31'b0, bus.imem_req}, 32'd0);
    check_eq("rst_pc",     pc, RESET_PC);
    check_eq("rst_valid",  {31'b0, instr_valid}, 32'd0);
    check_eq("rst_icount", icount, 32'd0);
    check_eq("rst_instr",  instr, 32'd0);
    reset = 1'b0;
    #1;
    m_pc = RESET_PC;
    m_icount = 32'd0;

    // Back-to-back sequential fetches, then a 3-cycle memory stall.
    plain(0); plain(0); plain(0);
    check_eq("seq_addr", bus.imem_addr, 32'h0000_000C);
    plain(3);

    // Jump to 0x100, then branch cases around it.
    run_instr({6'h02, 26'h40}, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0);
    check_eq("jmp_100", bus.imem_addr, 32'h0000_0100);
    run_instr($urandom, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 32'd0);
    check_eq("beq_back", bus.imem_addr, 32'h0000_00FC);
    plain(0);
    run_instr($urandom, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 32'd0);
    check_eq("beq_nt", bus.imem_addr, 32'h0000_0104);
    run_instr($urandom, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0, 32'd0);
    plain(1);
    run_instr($urandom, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 1'b0, 32'd0);
    check_eq("bne_fwd", bus.imem_addr, 32'h0000_0110);
    run_instr($urandom, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd5, 1'b0, 32'd0);
    check_eq("both_taken", bus.imem_addr, 32'h0000_0128);

    // Reach 0x1000_0040, then jump over a taken branch.
    off = (32'h1000_0040 - m_pc - 32'd4) >> 2;
    run_instr($urandom, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, off, 1'b0, 32'd0);
    check_eq("far_pc", bus.imem_addr, 32'h1000_0040);
    run_instr({6'h02, 26'h10}, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd5, 1'b0, 32'd0);
    check_eq("jmp_wins", bus.imem_addr, 32'h1000_0040);

    if (JR_EN) begin
      run_instr($urandom, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd5, 1'b1, 32'h0000_2003);
      check_eq("jr_tgt", bus.imem_addr, 32'h0000_2000);
    end

    // PC wrap from the top of the address space.
    off = (32'hFFFF_FFFC - m_pc - 32'd4) >> 2;
    run_instr($urandom, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, off, 1'b0, 32'd0);
    check_eq("top_pc", bus.imem_addr, 32'hFFFF_FFFC);
    plain(0);
    check_eq("wrap_pc", bus.imem_addr, 32'h0000_0000);

    // Reset in the middle of a memory stall.
    plain(0);
    bus.imem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_eq("rstw_req", {31'b0, bus.imem_req}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("rstw_pc",     pc, RESET_PC);
    check_eq("rstw_icount", icount, 32'd0);
    check_eq("rstw_valid",  {31'b0, instr_valid}, 32'd0);
    m_pc = RESET_PC;
    m_icount = 32'd0;

    // Reset while retiring in EXEC.
    plain(0); plain(0);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = $urandom;
    tick();
    bus.imem_ready = 1'b0;
    reset = 1'b1; retire = 1'b1; jump = 1'b1;
    #1;
    check_eq("rste_req", {31'b0, bus.imem_req}, 32'd0);
    tick();
    reset = 1'b0; retire = 1'b0;
    #1;
    check_eq("rste_pc",     pc, RESET_PC);
    check_eq("rste_icount", icount, 32'd0);
    check_eq("rste_valid",  {31'b0, instr_valid}, 32'd0);
    check_eq("rste_instr",  instr, 32'd0);
    m_pc = RESET_PC;
    m_icount = 32'd0;

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                $urandom, ($urandom_range(0, 3) == 0), $urandom);
    end
    check_eq("final_addr", bus.imem_addr, m_pc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
